// File: rtl/seq_muldiv_alu_pkg.sv
// seq_muldiv_alu_pkg: mode and FSM state encodings shared by the sequential ALU
package seq_muldiv_alu_pkg;
    localparam int MODE_W = 3;
    typedef enum logic [MODE_W-1:0] {
        MODE_MULU = 3'd0,
        MODE_DIVU = 3'd1,
        MODE_AND  = 3'd2,
        MODE_OR   = 3'd3,
        MODE_MULS = 3'd4,
        MODE_DIVS = 3'd5,
        MODE_XOR  = 3'd6,
        MODE_ILL  = 3'd7
    } mode_e;
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;
endpackage

// File: rtl/seq_muldiv_alu_muldiv_step.sv
// muldiv_step: one unsigned shift-add multiply or restoring shift-subtract divide iteration
module muldiv_step
    import seq_muldiv_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] i_shreg,
    input  logic [WIDTH-1:0]   i_opb,
    input  logic               i_div,
    output logic [2*WIDTH-1:0] o_shreg,
    output logic               o_qbit
);
    logic [WIDTH:0]   w_acc;
    logic [WIDTH:0]   w_win;
    logic [WIDTH-1:0] w_diff;
    logic             w_ge;
    // The divide window keeps the bit shifted out of the remainder so the compare never loses it
    always_comb begin
        w_acc   = {1'b0, i_shreg[2*WIDTH-1:WIDTH]} + (i_shreg[0] ? {1'b0, i_opb} : {(WIDTH+1){1'b0}});
        w_win   = i_shreg[2*WIDTH-1:WIDTH-1];
        w_ge    = w_win >= {1'b0, i_opb};
        w_diff  = w_win[WIDTH-1:0] - i_opb;
        o_qbit  = i_div && w_ge;
        o_shreg = i_div ? {(w_ge ? w_diff : w_win[WIDTH-1:0]), i_shreg[WIDTH-2:0], w_ge}
                        : {w_acc, i_shreg[WIDTH-1:1]};
    end
endmodule

// File: rtl/seq_muldiv_alu.sv
// seq_muldiv_alu: multi-cycle multiply/divide/logic ALU with valid/ready handshakes and held results
module seq_muldiv_alu
    import seq_muldiv_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [MODE_W-1:0]  mode,
    input  logic [WIDTH-1:0]   in_A,
    input  logic [WIDTH-1:0]   in_B,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out,
    output logic               dz,
    output logic               ill
);
    state_e             r_state, w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_shreg, r_out, w_step, w_fix, w_quick;
    logic [WIDTH-1:0]   r_opb, w_a_mag, w_b_mag, w_logic;
    logic               r_div, r_neg_q, r_neg_r, r_dz, r_ill;
    logic               w_accept, w_is_mul, w_is_div, w_sgn, w_b_zero, w_calc, w_qbit, w_last;
    mode_e              w_mode;

    assign w_mode   = mode_e'(mode);
    assign w_is_mul = w_mode == MODE_MULU || w_mode == MODE_MULS;
    assign w_is_div = w_mode == MODE_DIVU || w_mode == MODE_DIVS;
    assign w_sgn    = w_mode == MODE_MULS || w_mode == MODE_DIVS;
    assign w_b_zero = in_B == '0;
    assign w_calc   = w_is_mul || (w_is_div && !w_b_zero);
    assign w_accept = in_valid && in_ready;
    assign w_last   = r_cnt == CNT_W'(WIDTH - 1);
    assign w_a_mag  = (w_sgn && in_A[WIDTH-1]) ? -in_A : in_A;
    assign w_b_mag  = (w_sgn && in_B[WIDTH-1]) ? -in_B : in_B;
    assign w_logic  = w_mode == MODE_AND ? (in_A & in_B) :
                      w_mode == MODE_OR  ? (in_A | in_B) :
                      w_mode == MODE_XOR ? (in_A ^ in_B) : '0;
    assign w_quick  = w_is_div ? {in_A, {WIDTH{1'b1}}} : {{WIDTH{1'b0}}, w_logic};
    assign w_fix    = !r_div ? (r_neg_q ? -r_shreg : r_shreg) :
                      {(r_neg_r ? -r_shreg[2*WIDTH-1:WIDTH] : r_shreg[2*WIDTH-1:WIDTH]),
                       (r_neg_q ? -r_shreg[WIDTH-1:0] : r_shreg[WIDTH-1:0])};

    assign in_ready  = r_state == IDLE;
    assign out_valid = r_state == DONE;
    assign out       = r_out;
    assign dz        = r_dz;
    assign ill       = r_ill;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .i_shreg (r_shreg),
        .i_opb   (r_opb),
        .i_div   (r_div),
        .o_shreg (w_step),
        .o_qbit  (w_qbit)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else r_state <= w_next;
    end

    // Next state: quick ops skip CALC/FIX, DONE waits for downstream
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_next = w_calc ? CALC : DONE;
            CALC:    if (w_last) w_next = FIX;
            FIX:     w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Datapath: latch magnitudes on accept, iterate in CALC, sign-correct into the result in FIX
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_shreg <= '0;
            r_opb   <= '0;
            r_div   <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_out   <= '0;
            r_dz    <= 1'b0;
            r_ill   <= 1'b0;
        end else if (w_accept) begin
            r_cnt   <= '0;
            r_shreg <= {{WIDTH{1'b0}}, w_a_mag};
            r_opb   <= w_b_mag;
            r_div   <= w_is_div;
            r_neg_q <= w_sgn && (in_A[WIDTH-1] ^ in_B[WIDTH-1]);
            r_neg_r <= w_sgn && w_is_div && in_A[WIDTH-1];
            r_dz    <= w_is_div && w_b_zero;
            r_ill   <= w_mode == MODE_ILL;
            if (!w_calc) r_out <= w_quick;
        end else if (r_state == CALC) begin
            r_shreg <= {w_step[2*WIDTH-1:1], r_div ? w_qbit : w_step[0]};
            r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
        end else if (r_state == FIX) begin
            r_out <= w_fix;
        end
    end
endmodule

// File: tb/tb_seq_muldiv_alu.sv
// tb_seq_muldiv_alu: vector table plus scoreboard for the 32-bit ALU, hand sequences for an 8-bit one
module tb_seq_muldiv_alu;
    logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic        in_ready, out_valid, dz, ill;
    logic [2:0]  mode = 3'd0;
    logic [31:0] in_a = '0, in_b = '0;
    logic [63:0] out;

    logic        rst8_n = 1'b0, in_valid8 = 1'b0, out_ready8 = 1'b1;
    logic        in_ready8, out_valid8, dz8, ill8;
    logic [2:0]  mode8 = 3'd0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [15:0] out8;

    int passed = 0, total = 0;

    typedef struct {
        logic [2:0]  m;
        logic [31:0] a, b;
        logic [63:0] out;
        logic        dz, ill;
        int          hold;
    } vec_t;
    typedef struct {
        logic [63:0] out;
        logic        dz, ill;
    } exp_t;

    vec_t tbl[13];
    exp_t sb[$];

    seq_muldiv_alu #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
        .in_A(in_a), .in_B(in_b), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .dz(dz), .ill(ill)
    );

    seq_muldiv_alu #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst8_n), .in_valid(in_valid8), .in_ready(in_ready8), .mode(mode8),
        .in_A(a8), .in_B(b8), .out_valid(out_valid8), .out_ready(out_ready8),
        .out(out8), .dz(dz8), .ill(ill8)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic exp_t model(input logic [2:0] m, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        longint sa, sb_, q, r;
        e.out = '0; e.dz = 1'b0; e.ill = 1'b0;
        sa = longint'($signed(a));
        sb_ = longint'($signed(b));
        case (m)
            3'd0: e.out = {32'b0, a} * {32'b0, b};
            3'd4: e.out = sa * sb_;
            3'd1: begin
                if (b == 0) begin e.out = {a, 32'hFFFFFFFF}; e.dz = 1'b1; end
                else e.out = {a % b, a / b};
            end
            3'd5: begin
                if (b == 0) begin e.out = {a, 32'hFFFFFFFF}; e.dz = 1'b1; end
                else begin q = sa / sb_; r = sa % sb_; e.out = {r[31:0], q[31:0]}; end
            end
            3'd2: e.out = {32'b0, a & b};
            3'd3: e.out = {32'b0, a | b};
            3'd6: e.out = {32'b0, a ^ b};
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    function automatic int lat(input logic [2:0] m, input logic [31:0] b);
        return (m == 3'd0 || m == 3'd4 || ((m == 3'd1 || m == 3'd5) && b != 0)) ? 34 : 1;
    endfunction

    // Scoreboard: compare each result as it is handed off downstream
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                total++;
                $display("FAIL sb_underflow: got result %h expected none", out);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_out", out, e.out);
                chk("sb_dz", 64'(dz), 64'(e.dz));
                chk("sb_ill", 64'(ill), 64'(e.ill));
            end
        end
    end

    task automatic run(input vec_t v);
        int k;
        exp_t e;
        logic [63:0] held;
        @(negedge clk);
        mode = v.m; in_a = v.a; in_b = v.b; in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 50) begin @(negedge clk); k++; end
        chk("accept_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        e.out = v.out; e.dz = v.dz; e.ill = v.ill;
        sb.push_back(e);
        #1;
        in_valid = 1'b0; mode = 3'($urandom); in_a = $urandom; in_b = $urandom;
        k = 1;
        while (!out_valid && k < 100) begin @(posedge clk); #1; k++; end
        chk("latency", 64'(k), 64'(lat(v.m, v.b)));
        held = out;
        for (int i = 0; i < v.hold; i++) begin
            @(negedge clk);
            chk("hold_out", out, held);
            chk("hold_flags", {62'b0, out_valid, in_ready}, 64'b10);
        end
        out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("handoff", {62'b0, out_valid, in_ready}, 64'b01);
    endtask

    task automatic run8(input logic [2:0] m, input logic [7:0] a, input logic [7:0] b,
                        output logic [15:0] res, output int k);
        @(negedge clk);
        mode8 = m; a8 = a; b8 = b; in_valid8 = 1'b1;
        k = 0;
        while (!in_ready8 && k < 50) begin @(negedge clk); k++; end
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        k = 1;
        while (!out_valid8 && k < 50) begin @(posedge clk); #1; k++; end
        res = out8;
    endtask

    initial begin
        logic [15:0] r8;
        int k8;
        vec_t v;
        exp_t e;
        tbl = '{
            '{3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 1'b0, 1'b0, 0},
            '{3'd5, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 1'b0, 1'b0, 0},
            '{3'd5, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0, 1'b0, 2},
            '{3'd1, 32'd123,      32'd0,        64'h0000007B_FFFFFFFF, 1'b1, 1'b0, 0},
            '{3'd6, 32'hF0F0F0F0, 32'hFF00FF00, 64'h00000000_0FF00FF0, 1'b0, 1'b0, 5},
            '{3'd2, 32'hF0F0F0F0, 32'hFF00FF00, 64'h00000000_F000F000, 1'b0, 1'b0, 0},
            '{3'd3, 32'hF0F0F0F0, 32'hFF00FF00, 64'h00000000_FFF0FFF0, 1'b0, 1'b0, 0},
            '{3'd7, 32'd1234,     32'd5,        64'h00000000_00000000, 1'b0, 1'b1, 1},
            '{3'd4, 32'hFFFFFFFF, 32'h00000001, 64'hFFFFFFFF_FFFFFFFF, 1'b0, 1'b0, 0},
            '{3'd0, 32'h12345678, 32'h00000010, 64'h00000001_23456780, 1'b0, 1'b0, 0},
            '{3'd1, 32'd100,      32'd7,        64'h00000002_0000000E, 1'b0, 1'b0, 0},
            '{3'd5, 32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 1'b0, 1'b0, 0},
            '{3'd5, 32'hFFFFFFFB, 32'h00000000, 64'hFFFFFFFB_FFFFFFFF, 1'b1, 1'b0, 0}
        };
        repeat (2) @(negedge clk);
        chk("rst_flags", {60'b0, in_ready, out_valid, dz, ill}, 64'b1000);
        chk("rst_out", out, 64'd0);
        chk("rst8_flags", {60'b0, in_ready8, out_valid8, dz8, ill8}, 64'b1000);
        rst_n = 1'b1;
        rst8_n = 1'b1;
        foreach (tbl[i]) run(tbl[i]);
        for (int i = 0; i < 16; i++) begin
            v.m = 3'($urandom_range(0, 7));
            v.a = (i % 5 == 0) ? 32'($urandom_range(0, 300)) : $urandom;
            v.b = (i % 4 == 0) ? 32'd0 : (i % 3 == 0) ? 32'($urandom_range(1, 20)) : $urandom;
            e = model(v.m, v.a, v.b);
            v.out = e.out; v.dz = e.dz; v.ill = e.ill; v.hold = i % 3;
            run(v);
        end
        chk("sb_empty", 64'(sb.size()), 64'd0);

        run8(3'd4, 8'h80, 8'h80, r8, k8);
        chk("w8_muls_out", 64'(r8), 64'h4000);
        chk("w8_muls_lat", 64'(k8), 64'd10);
        @(negedge clk);
        mode8 = 3'd1; a8 = 8'd200; b8 = 8'd7; in_valid8 = 1'b1;
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst8_n = 1'b0;
        #1;
        chk("w8_midrst_flags", {60'b0, in_ready8, out_valid8, dz8, ill8}, 64'b1000);
        chk("w8_midrst_out", 64'(out8), 64'd0);
        @(negedge clk);
        rst8_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("w8_after_rst_idle", {62'b0, in_ready8, out_valid8}, 64'b10);
        run8(3'd1, 8'd200, 8'd7, r8, k8);
        chk("w8_divu_out", 64'(r8), 64'h041C);
        chk("w8_divu_lat", 64'(k8), 64'd10);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
